// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the exception FSM states, cause codes,
// memory address-select codes and the exception vector byte addresses.
package cpu_pkg;

  // Exception sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_VEC  = 2'b01,
    ST_LOAD = 2'b10
  } exc_state_t;

  // Latched exception cause
  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_OPCODE = 2'b01;
  localparam logic [1:0] CAUSE_OVF    = 2'b10;
  localparam logic [1:0] CAUSE_DIV0   = 2'b11;

  // Memory address mux select codes
  localparam logic [2:0] IORD_PC       = 3'b000;
  localparam logic [2:0] IORD_S        = 3'b001;
  localparam logic [2:0] IORD_SAIDA    = 3'b010;
  localparam logic [2:0] IORD_VEC_OPC  = 3'b011;
  localparam logic [2:0] IORD_VEC_OVF  = 3'b100;
  localparam logic [2:0] IORD_VEC_DIV0 = 3'b101;

  // Byte addresses the vector select codes point at
  localparam logic [7:0] VEC_ADDR_OPC  = 8'd253;
  localparam logic [7:0] VEC_ADDR_OVF  = 8'd254;
  localparam logic [7:0] VEC_ADDR_DIV0 = 8'd255;

  // Map a latched cause onto the address-select code of its vector byte
  function automatic logic [2:0] vec_sel(input logic [1:0] c);
    logic [2:0] sel;
    sel = IORD_VEC_DIV0;
    case (c)
      CAUSE_OPCODE: sel = IORD_VEC_OPC;
      CAUSE_OVF:    sel = IORD_VEC_OVF;
      default:      sel = IORD_VEC_DIV0;
    endcase
    return sel;
  endfunction

  // Highest-priority pending request: opcode > overflow > div0
  function automatic logic [1:0] prio_cause(input logic opc, input logic ovf,
                                            input logic div0);
    logic [1:0] c;
    c = CAUSE_NONE;
    if (opc)       c = CAUSE_OPCODE;
    else if (ovf)  c = CAUSE_OVF;
    else if (div0) c = CAUSE_DIV0;
    return c;
  endfunction

endpackage

// File: rtl/exception_unit_if.sv
// Signal bundle between the main control / datapath and the exception unit.
//
// Handshake: exc_* are level requests, only looked at while the unit is
// idle; a request seen at a rising edge in IDLE is accepted on that edge and
// no acknowledge is returned. busy is the stall: while busy is high the unit
// owns the memory address select and write enable, and the main control
// must hold off. pc_load is a single-cycle strobe qualifying pc_next.
interface exception_unit_if;
  import cpu_pkg::*;

  logic              exc_opcode;
  logic              exc_overflow;
  logic              exc_div0;
  logic [31:0]       pc_in;
  logic [31:0]       mem_rdata;
  logic [2:0]        ctrl_iordmux;
  logic              ctrl_memwr;

  logic [2:0]        iordmux;
  logic              memwr;
  logic [31:0]       pc_next;
  logic              pc_load;
  logic [31:0]       epc;
  logic [1:0]        cause;
  logic              busy;
  exc_state_t        state;

  // Main control / datapath side
  modport master (
    output exc_opcode, exc_overflow, exc_div0, pc_in, mem_rdata,
           ctrl_iordmux, ctrl_memwr,
    input  iordmux, memwr, pc_next, pc_load, epc, cause, busy, state
  );

  // Exception unit side
  modport slave (
    input  exc_opcode, exc_overflow, exc_div0, pc_in, mem_rdata,
           ctrl_iordmux, ctrl_memwr,
    output iordmux, memwr, pc_next, pc_load, epc, cause, busy, state
  );

endinterface

// File: rtl/exception_unit.sv
// Exception unit: on an invalid-opcode, overflow or divide-by-zero request
// it takes the memory address select, fetches the cause's vector byte,
// saves EPC and strobes the zero-extended handler address into PC.
module exception_unit
  import cpu_pkg::*;
#(
  parameter int          MEM_WAIT   = 1,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic             clk,
  input  logic             reset,
  exception_unit_if.slave  bus
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  exc_state_t  state_q, state_d;
  logic [2:0]  cnt_q;
  logic [31:0] epc_q;
  logic [1:0]  cause_q;
  logic        any_exc;

  // Upper read-data bits and the address documentation constants are not
  // needed by the logic; fold them into a sink so they read as deliberate.
  logic unused_bits;
  assign unused_bits = ^{bus.mem_rdata[31:8], VEC_ADDR_OPC, VEC_ADDR_OVF,
                         VEC_ADDR_DIV0, IORD_PC, IORD_S, IORD_SAIDA};

  assign any_exc = bus.exc_opcode | bus.exc_overflow | bus.exc_div0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Wait counter, EPC and cause; EPC/cause only change when a request is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_exc) begin
            cnt_q   <= '0;
            epc_q   <= bus.pc_in - EPC_OFFSET;
            cause_q <= prio_cause(bus.exc_opcode, bus.exc_overflow, bus.exc_div0);
          end
        end
        ST_VEC:  cnt_q <= cnt_q + 3'd1;
        default: ;
      endcase
    end
  end

  // Next state and outputs; requests are ignored outside IDLE
  always_comb begin
    state_d     = state_q;
    bus.iordmux = bus.ctrl_iordmux;
    bus.memwr   = bus.ctrl_memwr;
    bus.busy    = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_next = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_exc) state_d = ST_VEC;
      end
      ST_VEC: begin
        bus.iordmux = vec_sel(cause_q);
        bus.memwr   = 1'b0;
        bus.busy    = 1'b1;
        if (cnt_q == WAIT_LAST) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        bus.iordmux = vec_sel(cause_q);
        bus.memwr   = 1'b0;
        bus.busy    = 1'b1;
        bus.pc_load = 1'b1;
        bus.pc_next = {24'b0, bus.mem_rdata[7:0]};
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.epc   = epc_q;
  assign bus.cause = cause_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: a table of idle pass-through vectors followed by
// hand-written multi-cycle exception sequences, for MEM_WAIT = 1 and 3.
module tb_exception_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  exception_unit_if bus1 ();
  exception_unit_if bus3 ();

  exception_unit #(.MEM_WAIT(1), .EPC_OFFSET(32'd4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  exception_unit #(.MEM_WAIT(3), .EPC_OFFSET(32'd4)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- types / scoreboard ----------------
  typedef struct {
    logic [2:0]  exc;     // {opcode, overflow, div0}
    logic [31:0] pc_in;
    logic [31:0] rdata;
    logic [2:0]  ciord;
    logic        cwr;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [71:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [71:0] exp_q[$];

  // Expected record: {busy, pc_load, memwr, iordmux, pc_next, epc, cause}
  function automatic logic [71:0] mk(input logic busy, input logic pl,
                                     input logic wr, input logic [2:0] iord,
                                     input logic [31:0] pn, input logic [31:0] ep,
                                     input logic [1:0] ca);
    return {busy, pl, wr, iord, pn, ep, ca};
  endfunction

  function automatic stim_t st(input logic [2:0] exc, input logic [31:0] pc,
                               input logic [31:0] rd, input logic [2:0] ciord,
                               input logic cwr);
    stim_t s;
    s.exc = exc; s.pc_in = pc; s.rdata = rd; s.ciord = ciord; s.cwr = cwr;
    return s;
  endfunction

  function automatic logic [71:0] sample(input int which);
    if (which == 3)
      return {bus3.busy, bus3.pc_load, bus3.memwr, bus3.iordmux,
              bus3.pc_next, bus3.epc, bus3.cause};
    return {bus1.busy, bus1.pc_load, bus1.memwr, bus1.iordmux,
            bus1.pc_next, bus1.epc, bus1.cause};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input stim_t s);
    {bus1.exc_opcode, bus1.exc_overflow, bus1.exc_div0} = s.exc;
    {bus3.exc_opcode, bus3.exc_overflow, bus3.exc_div0} = s.exc;
    bus1.pc_in = s.pc_in;         bus3.pc_in = s.pc_in;
    bus1.mem_rdata = s.rdata;     bus3.mem_rdata = s.rdata;
    bus1.ctrl_iordmux = s.ciord;  bus3.ctrl_iordmux = s.ciord;
    bus1.ctrl_memwr = s.cwr;      bus3.ctrl_memwr = s.cwr;
  endtask

  task automatic compare(input string name, input int which);
    logic [71:0] e, a;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, actual=no expectation required=one", name);
    end else begin
      e = exp_q.pop_front();
      a = sample(which);
      if (a !== e) begin
        n_err++;
        $display("FAIL %s (dut%0d): actual busy=%b pl=%b wr=%b iord=%b pc_next=%h epc=%h cause=%b required busy=%b pl=%b wr=%b iord=%b pc_next=%h epc=%h cause=%b",
                 name, which, a[71], a[70], a[69], a[68:66], a[65:34], a[33:2], a[1:0],
                 e[71], e[70], e[69], e[68:66], e[65:34], e[33:2], e[1:0]);
      end
    end
  endtask

  // Apply inputs just after a rising edge, check at the falling edge,
  // then move to just after the next rising edge.
  task automatic step(input string name, input int which, input stim_t s,
                      input logic [71:0] e);
    drive(s);
    exp_q.push_back(e);
    @(negedge clk);
    compare(name, which);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t tbl[5];

  initial begin
    tbl[0] = '{st(3'b000, 32'h0000_0010, 32'h0, 3'b010, 1'b1), mk(0, 0, 1, 3'b010, 0, 0, 2'b00)};
    tbl[1] = '{st(3'b000, 32'h0000_0020, 32'hFFFF_FFFF, 3'b000, 1'b0), mk(0, 0, 0, 3'b000, 0, 0, 2'b00)};
    tbl[2] = '{st(3'b000, 32'h1234_5678, 32'h0000_00A8, 3'b001, 1'b1), mk(0, 0, 1, 3'b001, 0, 0, 2'b00)};
    tbl[3] = '{st(3'b000, 32'hFFFF_FFFF, 32'h5555_5555, 3'b111, 1'b0), mk(0, 0, 0, 3'b111, 0, 0, 2'b00)};
    tbl[4] = '{st(3'b000, 32'h0, 32'h0, 3'b101, 1'b1), mk(0, 0, 1, 3'b101, 0, 0, 2'b00)};

    // Reset state, with reset held
    drive(st(3'b000, 32'h0, 32'h0, 3'b010, 1'b1));
    reset = 1'b1;
    #12;
    exp_q.push_back(mk(0, 0, 1, 3'b010, 0, 0, 2'b00));
    compare("reset_state", 1);
    exp_q.push_back(mk(0, 0, 1, 3'b010, 0, 0, 2'b00));
    compare("reset_state", 3);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle pass-through table, plus a few random control codes
    for (int i = 0; i < 5; i++) step("passthru", 1, tbl[i].s, tbl[i].exp);
    for (int i = 0; i < 4; i++) begin
      logic [2:0] c;
      logic w;
      c = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      step("passthru_rand", 1, st(3'b000, 32'($urandom), 32'($urandom), c, w),
           mk(0, 0, w, c, 0, 0, 2'b00));
    end

    // Opcode exception, MEM_WAIT = 1
    step("opc_T",   1, st(3'b100, 32'h40, 32'h0,  3'b000, 1'b0), mk(0, 0, 0, 3'b000, 0, 0, 2'b00));
    step("opc_VEC", 1, st(3'b000, 32'h44, 32'h0,  3'b000, 1'b0), mk(1, 0, 0, 3'b011, 0, 32'h3C, 2'b01));
    step("opc_LD",  1, st(3'b000, 32'h44, 32'hA8, 3'b000, 1'b0), mk(1, 1, 0, 3'b011, 32'hA8, 32'h3C, 2'b01));
    step("opc_IDL", 1, st(3'b000, 32'h44, 32'hA8, 3'b010, 1'b1), mk(0, 0, 1, 3'b010, 0, 32'h3C, 2'b01));

    // Priority overflow over div0, requests held through the sequence
    step("pri_T",   1, st(3'b011, 32'h100, 32'h0,         3'b001, 1'b1), mk(0, 0, 1, 3'b001, 0, 32'h3C, 2'b01));
    step("pri_VEC", 1, st(3'b011, 32'h100, 32'h0,         3'b001, 1'b1), mk(1, 0, 0, 3'b100, 0, 32'hFC, 2'b10));
    step("pri_LD",  1, st(3'b011, 32'h100, 32'hFFFF_FF17, 3'b001, 1'b1), mk(1, 1, 0, 3'b100, 32'h17, 32'hFC, 2'b10));
    step("pri_IDL", 1, st(3'b000, 32'h100, 32'h0,         3'b001, 1'b1), mk(0, 0, 1, 3'b001, 0, 32'hFC, 2'b10));

    // Div0 with EPC wrap; opcode pulse during VEC must be ignored
    step("wrap_T",   1, st(3'b001, 32'h0, 32'h0,  3'b000, 1'b1), mk(0, 0, 1, 3'b000, 0, 32'hFC, 2'b10));
    step("wrap_VEC", 1, st(3'b100, 32'h0, 32'h0,  3'b000, 1'b1), mk(1, 0, 0, 3'b101, 0, 32'hFFFF_FFFC, 2'b11));
    step("wrap_LD",  1, st(3'b000, 32'h0, 32'h44, 3'b000, 1'b1), mk(1, 1, 0, 3'b101, 32'h44, 32'hFFFF_FFFC, 2'b11));
    step("wrap_ID1", 1, st(3'b000, 32'h0, 32'h44, 3'b000, 1'b1), mk(0, 0, 1, 3'b000, 0, 32'hFFFF_FFFC, 2'b11));
    step("wrap_ID2", 1, st(3'b000, 32'h0, 32'h44, 3'b000, 1'b1), mk(0, 0, 1, 3'b000, 0, 32'hFFFF_FFFC, 2'b11));

    // MEM_WAIT = 3: VEC three cycles, then one LOAD
    do_reset();
    step("mw3_T",    3, st(3'b010, 32'h200, 32'h0,  3'b010, 1'b0), mk(0, 0, 0, 3'b010, 0, 0, 2'b00));
    for (int i = 0; i < 3; i++)
      step("mw3_VEC", 3, st(3'b000, 32'h200, 32'h0, 3'b010, 1'b0), mk(1, 0, 0, 3'b100, 0, 32'h1FC, 2'b10));
    step("mw3_LD",   3, st(3'b000, 32'h200, 32'h99, 3'b010, 1'b0), mk(1, 1, 0, 3'b100, 32'h99, 32'h1FC, 2'b10));
    step("mw3_IDL",  3, st(3'b000, 32'h200, 32'h99, 3'b010, 1'b0), mk(0, 0, 0, 3'b010, 0, 32'h1FC, 2'b10));

    // Asynchronous reset in the middle of VEC (MEM_WAIT = 3)
    step("rst_T",   3, st(3'b001, 32'h80, 32'h0, 3'b001, 1'b1), mk(0, 0, 1, 3'b001, 0, 32'h1FC, 2'b10));
    step("rst_VEC", 3, st(3'b000, 32'h80, 32'h0, 3'b001, 1'b1), mk(1, 0, 0, 3'b101, 0, 32'h7C, 2'b11));
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(0, 0, 1, 3'b001, 0, 0, 2'b00));
    compare("rst_async", 3);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      step("rst_after", 3, st(3'b000, 32'h80, 32'hEE, 3'b001, 1'b1), mk(0, 0, 1, 3'b001, 0, 0, 2'b00));

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
